mux8_rr_scheduler: RTL

- Round-robin arbiter/scheduler that shares one 8-to-1 single-bit mux path among 8 requesters.
- Owns the 3-bit select bus (S3 = MSB) and a one-hot grant vector.
- Forwards the granted source bit to a single output.
- Enforces a maximum tenure per grant, so one requester cannot starve the others.

---
 rtl/mux8_rr_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mux8_rr_scheduler.sv
// rtl/mux8_rr_scheduler.sv - round-robin scheduler sharing one 8-to-1 single-bit mux path
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [7:0] request vector, bit i = source i wants the path
//   din    in   [7:0] source data, bit i = source i
//   sel    out  [2:0] registered mux select, index of the current owner
//   grant  out  [7:0] registered one-hot grant, zero when idle
//   valid  out  high whenever grant is non-zero
//   y      out  din[sel] while valid, else 0 (combinational)
//
// MAX_HOLD (1..15) bounds how many consecutive cycles an owner keeps the
// path while some other source is waiting.

module mux8_rr_scheduler #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       valid,
    output logic       y
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] last, last_nxt;
    logic [3:0] hold_cnt, hold_nxt;
    logic [2:0] sel_nxt;
    logic [7:0] grant_nxt;
    logic       valid_nxt;

    logic [7:0] owner_oh;
    logic [7:0] cand_mask;
    logic       others;
    logic       owner_req;
    logic [2:0] cand;
    logic [2:0] pick;
    logic       pick_found;

    // Round-robin pick. Scanning starts at last+1; while OWNED, last always
    // equals sel, so this is also "start after the owner". The owner is
    // masked out so a forced rotation can never re-select it.
    always_comb begin
        owner_oh   = (state == OWNED) ? (8'b1 << sel) : 8'h00;
        cand_mask  = req & ~owner_oh;
        others     = |cand_mask;
        owner_req  = |(req & owner_oh);
        pick       = last;
        pick_found = 1'b0;
        cand       = last;
        for (int k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!pick_found && cand_mask[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        sel_nxt   = sel;
        grant_nxt = grant;
        valid_nxt = valid;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = OWNED;
                    sel_nxt   = pick;
                    last_nxt  = pick;
                    grant_nxt = 8'b1 << pick;
                    valid_nxt = 1'b1;
                    hold_nxt  = 4'd0;
                end
            end
            OWNED: begin
                if (owner_req && !others) begin
                    // Uncontended: tenure limit does not apply.
                    hold_nxt = 4'd0;
                end else if (owner_req && hold_cnt < HOLD_LAST) begin
                    hold_nxt = hold_cnt + 4'd1;
                end else if (others) begin
                    // Forced rotation or voluntary hand-over, no idle bubble.
                    sel_nxt   = pick;
                    last_nxt  = pick;
                    grant_nxt = 8'b1 << pick;
                    hold_nxt  = 4'd0;
                end else begin
                    // Owner released and nobody waits; sel and last persist.
                    state_nxt = IDLE;
                    grant_nxt = 8'h00;
                    valid_nxt = 1'b0;
                    hold_nxt  = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 8'h00;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 3'd0;
            grant    <= 8'h00;
            valid    <= 1'b0;
            last     <= 3'd7;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            valid    <= valid_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        y = valid & din[sel];
    end

endmodule
